// File: rtl/harmonica_pkg.sv
// Shared harmonica definitions: note codes, FSM state encoding and system clock frequency.
package harmonica_pkg;

    localparam int unsigned NOTE_W   = 4;
    localparam int unsigned CLK_FREQ = 100_000_000;

    localparam logic [NOTE_W-1:0] NOTE_C = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_D = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_E = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_F = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_G = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_A = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_B = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: output follows key_s_i only after it has differed for DEBOUNCE_CYC consecutive cycles.
module key_debounce
    import harmonica_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_s_i,
    output logic key_o
);
    localparam int unsigned        CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (key_s_i != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = key_s_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign key_o = stable_q;

endmodule

// File: rtl/key_tone_arbiter.sv
// Synchronizes the harmonica keys, picks the lowest-index pressed key and drives the square-wave tone.
// Per-key debouncing is built in only when HARMONICA_DEBOUNCE_EN is defined.
//
// state | meaning
// IDLE  | silent, waiting for any key
// LOAD  | note_o presented, half-period captured from note_selector
// PLAY  | tone toggling every div_reg cycles, minimum hold enforced
module key_tone_arbiter
    import harmonica_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 7,
    parameter int unsigned DIV_W        = 32,
    parameter int unsigned MIN_HOLD_CYC = 5_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    input  logic [DIV_W-1:0]    div_value_i,
    output logic [NOTE_W-1:0]   note_o,
    output logic                tone_o,
    output logic                active_o
);
    localparam int unsigned       HOLD_W   = $clog2(MIN_HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYC);

    if (MIN_HOLD_CYC < 1 || DEBOUNCE_CYC < 1) begin : g_bad_cfg
        $error("key_tone_arbiter: MIN_HOLD_CYC and DEBOUNCE_CYC must be at least 1");
    end

    logic [NUM_KEYS-1:0] key_m_q, key_s_q, key_arb;
    logic [NOTE_W-1:0]   winner;
    logic                req, hold_ok;

    state_e              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    half_q, half_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                tone_q, tone_d;
    logic                active_q, active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m_q <= '0;
            key_s_q <= '0;
        end else begin
            key_m_q <= key_i;
            key_s_q <= key_m_q;
        end
    end

`ifdef HARMONICA_DEBOUNCE_EN
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_s_i (key_s_q[g]),
            .key_o   (key_arb[g])
        );
    end
`else
    assign key_arb = key_s_q;
`endif

    // Scan from the top down so the lowest pressed index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_arb[i]) winner = NOTE_W'(i);
        end
    end

    assign req     = |key_arb;
    assign hold_ok = (hold_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        div_d   = div_q;
        half_d  = half_q;
        hold_d  = hold_q;
        tone_d  = tone_q;
        unique case (state_q)
            ST_IDLE: begin
                tone_d = 1'b0;
                if (req) begin
                    note_d  = winner;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                div_d   = (div_value_i == '0) ? DIV_W'(1) : div_value_i;
                half_d  = '0;
                hold_d  = '0;
                tone_d  = 1'b1;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (half_q == div_q - DIV_W'(1)) begin
                    tone_d = ~tone_q;
                    half_d = '0;
                end else begin
                    half_d = half_q + DIV_W'(1);
                end
                if (!hold_ok) hold_d = hold_q + HOLD_W'(1);
                if (hold_ok && !req) begin
                    tone_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (hold_ok && winner != note_q) begin
                    note_d  = winner;
                    tone_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                tone_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            note_q   <= '0;
            div_q    <= '0;
            half_q   <= '0;
            hold_q   <= '0;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            div_q    <= div_d;
            half_q   <= half_d;
            hold_q   <= hold_d;
            tone_q   <= tone_d;
            active_q <= active_d;
        end
    end

    assign note_o   = note_q;
    assign tone_o   = tone_q;
    assign active_o = active_q;

endmodule

// File: tb/tb_key_tone_arbiter.sv
// Self-checking bench for key_tone_arbiter: directed scenarios plus random key traffic against a timing model.
module tb_key_tone_arbiter;

    localparam int HOLD = 8;
    localparam int DEB  = 4;
`ifdef HARMONICA_DEBOUNCE_EN
    localparam int LAT  = DEB;
`else
    localparam int LAT  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  key_i = '0;
    logic [31:0] div_value_i;
    logic [3:0]  note_o;
    logic        tone_o;
    logic        active_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // note_selector stub
    assign div_value_i = 32'(note_o) + 32'd3;

    key_tone_arbiter #(
        .NUM_KEYS     (7),
        .DIV_W        (32),
        .MIN_HOLD_CYC (HOLD),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_i       (key_i),
        .div_value_i (div_value_i),
        .note_o      (note_o),
        .tone_o      (tone_o),
        .active_o    (active_o)
    );

    // Reference model: key history, accepted keys, and the current note as phase + start time.
    logic [6:0] hist [0:7];
    logic [6:0] m_deb;
    int         m_phase;
    int         m_cyc, m_start, m_div;
    logic [3:0] m_note;
    logic       m_tone, m_active;

    function automatic logic [3:0] lowest(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 8; j++) hist[j] = '0;
        m_deb = '0; m_phase = 0; m_cyc = 0; m_start = 0; m_div = 1;
        m_note = '0; m_tone = 1'b0; m_active = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] kin);
        logic [6:0] ks, nd;
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = kin;
        ks = (LAT != 0) ? m_deb : hist[2];
        nd = m_deb;
        for (int b = 0; b < 7; b++)
            if (hist[2][b] != m_deb[b] && hist[3][b] != m_deb[b] &&
                hist[4][b] != m_deb[b] && hist[5][b] != m_deb[b]) nd[b] = ~m_deb[b];
        m_deb = nd;
        case (m_phase)
            0: if (ks != 0) begin m_note = lowest(ks); m_phase = 1; end
            1: begin m_div = int'(m_note) + 3; m_start = m_cyc; m_phase = 2; end
            default:
                // note may end only once it has sounded HOLD counted cycles after PLAY entry
                if (m_cyc - m_start > HOLD) begin
                    if (ks == 0) m_phase = 0;
                    else if (lowest(ks) != m_note) begin m_note = lowest(ks); m_phase = 1; end
                end
        endcase
        m_active = (m_phase != 0);
        m_tone   = (m_phase == 2) && ((((m_cyc - m_start) / m_div) % 2) == 0);
        m_cyc++;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (active_o === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_i = 7'h7F;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (tone_o !== 1'b0 || active_o !== 1'b0 || note_o !== 4'd0) begin
                failures++;
                $display("FAIL reset c=%0d tone=%b active=%b note=%0d required 0 0 0", c, tone_o, active_o, note_o);
            end
        end
        @(negedge clk); key_i = '0; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (active_o !== 1'b0) begin
                failures++; $display("FAIL post_reset_idle c=%0d active=%b required 0", c, active_o);
            end
        end
    endtask

    task automatic test_single_key();
        bit ok;
        @(negedge clk); key_i = 7'h04;
        for (int e = 0; e <= 12 + LAT; e++) begin
            @(posedge clk); #1;
            if (e == 1 + LAT) begin
                checks++;
                if (active_o !== 1'b0) begin failures++; $display("FAIL single_early e=%0d active=%b required 0", e, active_o); end
            end
            if (e == 2 + LAT) begin
                checks++;
                if (note_o !== 4'd2 || active_o !== 1'b1 || tone_o !== 1'b0) begin
                    failures++;
                    $display("FAIL single_load e=%0d note=%0d active=%b tone=%b required 2 1 0", e, note_o, active_o, tone_o);
                end
            end
            if (e >= 3 + LAT) begin
                checks++;
                if (tone_o !== (((e - 3 - LAT) / 5) % 2 == 0)) begin
                    failures++; $display("FAIL single_period e=%0d tone=%b required %b", e, tone_o, (((e - 3 - LAT) / 5) % 2 == 0));
                end
            end
        end
        @(negedge clk); key_i = '0;
        wait_idle(ok);
        checks++;
        if (!ok || tone_o !== 1'b0) begin
            failures++; $display("FAIL single_release idle=%b tone=%b required 1 0", ok, tone_o);
        end
    endtask

    task automatic test_priority();
        bit ok;
        @(negedge clk); key_i = 7'h30;
        for (int e = 0; e <= 15 + LAT; e++) begin
            @(posedge clk); #1;
            if (e == 2 + LAT || e == 15 + LAT) begin
                checks++;
                if (note_o !== 4'd4 || active_o !== 1'b1) begin
                    failures++; $display("FAIL priority_first e=%0d note=%0d active=%b required 4 1", e, note_o, active_o);
                end
            end
        end
        @(negedge clk); key_i = 7'h20;
        for (int f = 0; f <= 18 + LAT; f++) begin
            @(posedge clk); #1;
            if (f == 1 + LAT) begin
                checks++;
                if (note_o !== 4'd4) begin failures++; $display("FAIL priority_hold f=%0d note=%0d required 4", f, note_o); end
            end
            if (f == 2 + LAT) begin
                checks++;
                if (note_o !== 4'd5 || tone_o !== 1'b0 || active_o !== 1'b1) begin
                    failures++;
                    $display("FAIL priority_reload f=%0d note=%0d tone=%b active=%b required 5 0 1", f, note_o, tone_o, active_o);
                end
            end
            if (f >= 3 + LAT) begin
                checks++;
                if (tone_o !== (((f - 3 - LAT) / 8) % 2 == 0)) begin
                    failures++; $display("FAIL priority_period f=%0d tone=%b required %b", f, tone_o, (((f - 3 - LAT) / 8) % 2 == 0));
                end
            end
        end
        @(negedge clk); key_i = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL priority_release idle=%b required 1", ok); end
    endtask

    task automatic test_short_tap();
        int tap;
        tap = (LAT == 0) ? 1 : DEB;
        @(negedge clk); key_i = 7'h01;
        for (int e = 0; e <= 13 + LAT; e++) begin
            @(posedge clk); #1;
            if (e < 2 + LAT || e >= 12 + LAT) begin
                checks++;
                if (active_o !== 1'b0 || tone_o !== 1'b0) begin
                    failures++; $display("FAIL tap_idle e=%0d active=%b tone=%b required 0 0", e, active_o, tone_o);
                end
            end
            if (e == 2 + LAT) begin
                checks++;
                if (note_o !== 4'd0 || active_o !== 1'b1) begin
                    failures++; $display("FAIL tap_load e=%0d note=%0d active=%b required 0 1", e, note_o, active_o);
                end
            end
            if (e > 2 + LAT && e < 12 + LAT) begin
                checks++;
                if (active_o !== 1'b1) begin failures++; $display("FAIL tap_hold e=%0d active=%b required 1", e, active_o); end
            end
            if (e == tap - 1) begin @(negedge clk); key_i = '0; end
        end
    endtask

    task automatic test_reset_mid_note();
        bit ok;
        @(negedge clk); key_i = 7'h08;
        for (int e = 0; e <= 5 + LAT; e++) begin
            @(posedge clk); #1;
            if (e == 3 + LAT) begin
                checks++;
                if (tone_o !== 1'b1 || note_o !== 4'd3) begin
                    failures++; $display("FAIL midreset_play e=%0d tone=%b note=%0d required 1 3", e, tone_o, note_o);
                end
            end
        end
        #2; rst_n = 1'b0; #1;
        checks++;
        if (tone_o !== 1'b0 || active_o !== 1'b0 || note_o !== 4'd0) begin
            failures++; $display("FAIL midreset_clear tone=%b active=%b note=%0d required 0 0 0", tone_o, active_o, note_o);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int e = 0; e <= 3 + LAT; e++) begin
            @(posedge clk); #1;
            if (e == 1 + LAT) begin
                checks++;
                if (active_o !== 1'b0) begin failures++; $display("FAIL midreset_wait e=%0d active=%b required 0", e, active_o); end
            end
            if (e == 2 + LAT) begin
                checks++;
                if (note_o !== 4'd3 || active_o !== 1'b1) begin
                    failures++; $display("FAIL midreset_restart e=%0d note=%0d active=%b required 3 1", e, note_o, active_o);
                end
            end
            if (e == 3 + LAT) begin
                checks++;
                if (tone_o !== 1'b1) begin failures++; $display("FAIL midreset_tone e=%0d tone=%b required 1", e, tone_o); end
            end
        end
        @(negedge clk); key_i = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_release idle=%b required 1", ok); end
    endtask

`ifdef HARMONICA_DEBOUNCE_EN
    task automatic test_debounce();
        bit ok;
        @(negedge clk); key_i = 7'h02;
        @(negedge clk); @(negedge clk); key_i = '0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            checks++;
            if (active_o !== 1'b0) begin failures++; $display("FAIL debounce_glitch c=%0d active=%b required 0", c, active_o); end
        end
        @(negedge clk); key_i = 7'h02;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            if (e < 6) begin
                checks++;
                if (active_o !== 1'b0) begin failures++; $display("FAIL debounce_wait e=%0d active=%b required 0", e, active_o); end
            end else begin
                checks++;
                if (note_o !== 4'd1 || active_o !== 1'b1) begin
                    failures++; $display("FAIL debounce_accept e=%0d note=%0d active=%b required 1 1", e, note_o, active_o);
                end
            end
            if (e == 5) begin @(negedge clk); key_i = '0; end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL debounce_release idle=%b required 1", ok); end
    endtask
`endif

    task automatic test_random();
        logic [6:0] kv;
        int         hold_left;
        @(negedge clk); rst_n = 1'b0; key_i = '0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        kv = '0; hold_left = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold_left == 0) begin
                case ($urandom_range(0, 3))
                    0: kv = '0;
                    1: kv = 7'(1 << $urandom_range(0, 6));
                    2: kv = 7'($urandom);
                    default: kv = kv;
                endcase
                hold_left = $urandom_range(1, 25);
            end
            hold_left--;
            @(negedge clk); key_i = kv;
            @(posedge clk);
            model_step(kv);
            #1;
            checks++;
            if (note_o !== m_note || tone_o !== m_tone || active_o !== m_active) begin
                failures++;
                $display("FAIL random c=%0d key=%h note=%0d tone=%b active=%b required %0d %b %b",
                         c, kv, note_o, tone_o, active_o, m_note, m_tone, m_active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_priority();
        test_short_tap();
        test_reset_mid_note();
`ifdef HARMONICA_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
